// File: rtl/hilo_muldiv_if.sv
// Pipeline <-> HI/LO multiply/divide unit bundle.
// master: EX-stage control side; slave: the muldiv unit.
interface hilo_muldiv_if;
  logic        hiloW;
  logic [3:0]  con;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiloR;
  logic        hiloS;
  logic [31:0] hiloOut;
  logic        busy;
  logic        stall;
  logic        done;
  logic        divZero;

  modport master (
    output hiloW, con, a, b, hiloR, hiloS,
    input  hiloOut, busy, stall, done, divZero
  );

  modport slave (
    input  hiloW, con, a, b, hiloR, hiloS,
    output hiloOut, busy, stall, done, divZero
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit mul/div engine owning the HI/LO pair.
// Ports: clk, reset (sync, active-high), bus (hilo_muldiv_if.slave).
module hilo_muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]  r_cnt;
  logic        r_isDiv;
  logic        r_sgnQ;
  logic        r_sgnR;
  logic        r_bZero;
  logic        r_done;
  logic        r_divZero;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_acc;

  logic        w_start;
  logic        w_signed;
  logic        w_last;
  logic        w_busy;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_mulSum;
  logic [32:0] w_remSh;
  logic [32:0] w_divDiff;
  logic        w_ge;
  logic [63:0] w_accNext;
  logic [63:0] w_prodFix;
  logic [31:0] w_quoFix;
  logic [31:0] w_remFix;
  logic [31:0] w_hiNew;
  logic [31:0] w_loNew;

  assign w_start  = bus.hiloW
                  & (bus.con[3:2] == 2'b11);
  assign w_signed = bus.con[1];
  assign w_last   = (r_cnt == 5'd31);
  assign w_busy   = (r_state != S_IDLE);

  assign w_absA = (w_signed & bus.a[31])
                ? (~bus.a + 32'd1) : bus.a;
  assign w_absB = (w_signed & bus.b[31])
                ? (~bus.b + 32'd1) : bus.b;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_CALC;
      S_CALC:  if (w_last)  w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply: acc = {partial, multiplier}; add at top,
  // shift right with the carry as the new MSB.
  // Divide: acc = {remainder, quotient}; shift left one,
  // subtract divisor when it fits, shift in quotient bit.
  always_comb begin
    w_mulSum  = {1'b0, r_acc[63:32]}
              + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_remSh   = r_acc[63:31];
    w_ge      = (w_remSh >= {1'b0, r_b});
    w_divDiff = w_remSh - {1'b0, r_b};
    if (r_isDiv) begin
      if (w_ge)
        w_accNext = {w_divDiff[31:0],
                     r_acc[30:0], 1'b1};
      else
        w_accNext = {w_remSh[31:0],
                     r_acc[30:0], 1'b0};
    end else begin
      w_accNext = {w_mulSum, r_acc[31:1]};
    end
  end

  // With b=0 the remainder path reassembles |a| and the
  // sign fix restores a, so only LO needs forcing.
  always_comb begin
    w_prodFix = r_sgnQ ? (~r_acc + 64'd1) : r_acc;
    w_quoFix  = r_sgnQ ? (~r_acc[31:0] + 32'd1)
                       : r_acc[31:0];
    w_remFix  = r_sgnR ? (~r_acc[63:32] + 32'd1)
                       : r_acc[63:32];
    if (r_isDiv) begin
      w_hiNew = w_remFix;
      w_loNew = r_bZero ? 32'hFFFF_FFFF : w_quoFix;
    end else begin
      w_hiNew = w_prodFix[63:32];
      w_loNew = w_prodFix[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 5'd0;
      r_isDiv   <= 1'b0;
      r_sgnQ    <= 1'b0;
      r_sgnR    <= 1'b0;
      r_bZero   <= 1'b0;
      r_b       <= 32'd0;
      r_acc     <= 64'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_isDiv   <= bus.con[0];
            r_sgnQ    <= w_signed
                       & (bus.a[31] ^ bus.b[31]);
            r_sgnR    <= w_signed & bus.a[31];
            r_bZero   <= (bus.b == 32'd0);
            r_b       <= w_absB;
            r_acc     <= {32'd0, w_absA};
            r_cnt     <= 5'd0;
            r_divZero <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_hi      <= w_hiNew;
          r_lo      <= w_loNew;
          r_done    <= 1'b1;
          r_divZero <= r_isDiv & r_bZero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.stall   = w_busy
                     & (bus.hiloR | bus.hiloW);
  assign bus.hiloOut = bus.hiloS ? r_lo : r_hi;
  assign bus.done    = r_done;
  assign bus.divZero = r_divZero;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit.
// Directed plan items plus random ops vs arithmetic model.
module tb_hilo_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_if bus ();

  hilo_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [3:0]  c,
                       input  logic [31:0] x,
                       input  logic [31:0] y,
                       output logic [31:0] h,
                       output logic [31:0] l,
                       output bit          z);
    logic [63:0] p;
    longint sx, sy, q, r;
    z = 0;
    h = 0;
    l = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (c[0] == 1'b0) begin
      if (c[1])
        p = 64'(sx * sy);
      else
        p = {32'd0, x} * {32'd0, y};
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
      z = 1;
    end else if (c[1]) begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endtask

  task automatic run_op(input logic [3:0]  c,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit          rd);
    logic [31:0] eh, el;
    bit ez;
    int nb, ns, nbad;
    model(c, x, y, eh, el, ez);
    @(negedge clk);
    bus.hiloW = 1; bus.con = c;
    bus.a = x; bus.b = y;
    bus.hiloR = 0; bus.hiloS = 0;
    @(negedge clk);
    bus.hiloW = 0;
    bus.a = $urandom; bus.b = $urandom;
    bus.hiloR = rd;
    #1;
    chk("divzero_clr_on_start", bus.divZero, 0);
    nb = 0; ns = 0; nbad = 0;
    while (!bus.done && nb < 40) begin
      if (bus.busy) nb++;
      if (bus.stall) ns++;
      if (bus.hiloOut !== m_hi) nbad++;
      @(negedge clk);
    end
    #1;
    chk("busy_cycles", nb, 33);
    chk("stall_cycles", ns, rd ? 33 : 0);
    chk("old_hi_while_busy", nbad, 0);
    chk("done_pulse", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("stall_at_done", bus.stall, 0);
    chk("hi_result", bus.hiloOut, eh);
    bus.hiloS = 1;
    #1;
    chk("lo_result", bus.hiloOut, el);
    chk("divzero_flag", bus.divZero, ez);
    bus.hiloR = 0;
    bus.hiloS = 0;
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    logic [31:0] e1h, e1l, e2h, e2l;
    bit z1, z2;
    int n, gap;
    logic [3:0]  rc;
    logic [31:0] rx, ry;
    checks = 0;
    failures = 0;
    m_hi = 0;
    m_lo = 0;
    reset = 1;
    bus.hiloW = 0; bus.con = 0;
    bus.a = 0; bus.b = 0;
    bus.hiloR = 0; bus.hiloS = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_divzero", bus.divZero, 0);
    chk("rst_hi", bus.hiloOut, 0);
    bus.hiloS = 1;
    #1 chk("rst_lo", bus.hiloOut, 0);
    bus.hiloR = 1;
    #1 chk("rst_stall", bus.stall, 0);
    bus.hiloR = 0; bus.hiloS = 0;
    reset = 0;

    run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("umul_hi_const", m_hi, 32'hFFFF_FFFE);
    run_op(4'b1110, 32'hFFFF_FFFD, 32'd7, 0);
    chk("smul_lo_const", m_lo, 32'hFFFF_FFEB);
    bus.hiloR = 1; bus.hiloS = 1;
    #1 chk("mfhilo_lo", bus.hiloOut, 32'hFFFF_FFEB);
    bus.hiloR = 0; bus.hiloS = 0;
    run_op(4'b1111, 32'hFFFF_FFF9, 32'd2, 0);
    chk("sdiv_lo_const", m_lo, 32'hFFFF_FFFD);
    run_op(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("sdiv_ovf_lo", m_lo, 32'h8000_0000);
    run_op(4'b1101, 32'h1234_5678, 32'd0, 0);
    chk("div0_hi_const", m_hi, 32'h1234_5678);
    run_op(4'b1111, 32'h8000_0000, 32'd0, 0);
    run_op(4'b1100, 32'hDEAD_BEEF, 32'h0000_1234, 1);

    @(negedge clk);
    bus.hiloW = 1; bus.con = 4'b0101;
    bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.hiloW = 0;
    #1 chk("ignored_code_busy", bus.busy, 0);
    chk("ignored_code_hi", bus.hiloOut, m_hi);

    model(4'b1110, 32'h0001_0003, 32'hFFF0_0007,
          e1h, e1l, z1);
    model(4'b1101, 32'hCAFE_F00D, 32'h0000_0013,
          e2h, e2l, z2);
    @(negedge clk);
    bus.hiloW = 1; bus.con = 4'b1110;
    bus.a = 32'h0001_0003; bus.b = 32'hFFF0_0007;
    @(negedge clk);
    bus.hiloW = 0;
    repeat (4) @(negedge clk);
    bus.hiloW = 1; bus.con = 4'b1101;
    bus.a = 32'hCAFE_F00D; bus.b = 32'h0000_0013;
    #1 chk("b2b_stall", bus.stall, 1);
    n = 0;
    while (!bus.done && n < 50) begin
      n++;
      @(negedge clk);
    end
    #1 chk("b2b_done1", bus.done, 1);
    chk("b2b_hi1", bus.hiloOut, e1h);
    bus.hiloS = 1;
    #1 chk("b2b_lo1", bus.hiloOut, e1l);
    bus.hiloS = 0;
    @(negedge clk);
    bus.hiloW = 0;
    #1 chk("b2b_accepted", bus.busy, 1);
    gap = 1;
    while (!bus.done && gap < 60) begin
      gap++;
      @(negedge clk);
    end
    #1 chk("b2b_gap", gap, 34);
    chk("b2b_hi2", bus.hiloOut, e2h);
    bus.hiloS = 1;
    #1 chk("b2b_lo2", bus.hiloOut, e2l);
    bus.hiloS = 0;
    m_hi = e2h; m_lo = e2l;
    @(negedge clk);

    bus.hiloW = 1; bus.con = 4'b1101;
    bus.a = 32'h7777_0000; bus.b = 32'd0;
    @(negedge clk);
    bus.hiloW = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1 chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_divzero", bus.divZero, 0);
    chk("rstmid_hi", bus.hiloOut, 0);
    bus.hiloS = 1;
    #1 chk("rstmid_lo", bus.hiloOut, 0);
    bus.hiloS = 0;
    m_hi = 0; m_lo = 0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) n++;
    end
    chk("rstmid_no_done", n, 0);
    run_op(4'b1101, 32'd100, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      rc = {2'b11, 2'($urandom)};
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = 32'd0;
      if ($urandom_range(0, 7) == 0) ry = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      run_op(rc, rx, ry, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide engine with the architectural HI/LO register pair, in the EX stage downstream of the ALU control decoder. It receives the decoder's ALU control code, HI/LO write strobe and HI/LO read/select strobes. It runs 32-bit signed/unsigned multiply and divide over multiple cycles and writes HI/LO on completion. It serves move-from-HI/LO reads and asks the pipeline to stall while busy.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- hiloW  in  1  start request (multiply/divide instruction in EX).
- con  in  4  ALU control code:
  - 1100 unsigned multiply
  - 1101 unsigned divide
  - 1110 signed multiply
  - 1111 signed divide
  - any other code with hiloW=1 is ignored.
- a  in  32  operand A (multiplicand / dividend).
- b  in  32  operand B (multiplier / divisor).
- hiloR  in  1  move-from-HI/LO instruction in EX.
- hiloS  in  1  read select: 0 = HI, 1 = LO.
- hiloOut  out  32  combinational read data: HI if hiloS=0, else LO (independent of hiloR).
- busy  out  1  engine running (state CALC or FIX).
- stall  out  1  combinational busy & (hiloR | hiloW); pipeline holds EX while high.
- done  out  1  one-cycle registered pulse; HI/LO hold the new result during this cycle.
- divZero  out  1  registered; set with done when a divide had b=0; cleared by the next accepted start or reset.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - Start is accepted when hiloW=1 and con[3:2]=11.
  - On acceptance, latch the operation type (mul/div) and signedness, then go to CALC with counter=0.
  - For signed operations:
    - Latch |a| and |b| as 32-bit unsigned values. |-2^31| = 0x80000000.
    - Latch the result sign: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
  - For unsigned operations, latch a and b raw with sign flags 0.
- CALC runs exactly 32 iterations, one per cycle, then goes to FIX.
  - Multiply: radix-2 shift-add over a 64-bit accumulator.
  - Divide: restoring division over a 64-bit remainder:quotient register.
- FIX (one cycle):
  - Negate the 64-bit product if its sign flag is set.
  - For divide, negate the quotient and/or remainder per their sign flags.
  - Write HI/LO on the edge leaving FIX, then go to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
- Divide by zero (b=0):
  - HI = a (original, unmodified), LO = 0xFFFFFFFF, divZero=1.
  - Applies regardless of signedness.
  - Latency is still full; CALC is not skipped.
- Signed overflow (-2^31 / -1): LO = 0x80000000, HI = 0. Falls out of the abs/negate method.
- hiloW while busy: ignored (no restart). stall holds the instruction; it is accepted in the first IDLE cycle.
- hiloR while busy: stall=1. hiloOut shows the old HI/LO until the write edge.
- HI/LO are written only at FIX exit. They keep their value across unrelated instructions.

## Timing
- Start edge E0 (hiloW sampled in IDLE).
- CALC is active from E0 to E32 (32 cycles); FIX runs E32 to E33; HI/LO are written at E33.
- busy=1 in the cycles after E0 through E33, i.e. 33 cycles, and 0 from E33 on.
- done=1 for exactly the cycle after E33, concurrently with busy=0. A new start may be accepted at the end of that cycle (back-to-back ops).
- A read (hiloR) held by stall completes in the cycle after E33 and returns the new value.
- Reset mid-operation:
  - Aborts immediately: state=IDLE, HI=LO=0.
  - busy=0, done=0, divZero=0 on the cycle after the reset edge.
  - No partial result is written.
- Reset values: HI=0, LO=0, busy=0, stall=0 (given inputs), done=0, divZero=0, hiloOut=0.

## Test plan
- Unsigned multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, con=1100 -> busy for 33 cycles, done pulse, HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply: a=-3 (0xFFFFFFFD), b=7, con=1110 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then hiloR=1, hiloS=1 -> hiloOut=0xFFFFFFEB.
- Signed divide:
  - a=-7, b=2, con=1111 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Then a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: a=0x12345678, b=0, con=1101 -> HI=0x12345678, LO=0xFFFFFFFF, divZero=1 with done. The next start clears divZero.
- Stall/hazard:
  - Start a multiply, then assert hiloR=1 on the next cycle -> stall=1 for 32 further cycles, with hiloOut=old HI.
  - A second hiloW during busy is not restarted. It is accepted the cycle done=1, and its done comes 34 cycles after the first done.
- Reset mid-op: assert reset at cycle 10 of a divide -> HI=LO=0, busy=0, no done pulse. A fresh start afterwards completes normally.
